// File: rtl/apb_arbiter_master.sv
// apb_arbiter_master: APB master shared round-robin among NREQ local requesters.
// Sequences SETUP/ACCESS, waits on PREADY (with optional timeout abort) and
// returns a one-cycle completion pulse with read data / error to the winner.
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   req_valid/req_write           per-requester request and direction
//   req_addr/req_wdata            packed per-requester address / write data
//   req_done                      one-hot completion pulse
//   rsp_rdata/rsp_err             response, valid while req_done != 0
//   busy                          bus owned (state != IDLE)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request side
//   PRDATA/PREADY/PSLVERR         APB response side
module apb_arbiter_master #(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_done,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AWIDTH-1:0]        PADDR,
  output logic [DWIDTH-1:0]        PWDATA,
  input  logic [DWIDTH-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gnt_q, gnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [AWIDTH-1:0]   paddr_q, paddr_d;
  logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
  logic [NREQ-1:0]     req_done_q, req_done_d;
  logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic [NREQ-1:0]     eligible_c;
  logic [PW-1:0]       win_c;
  logic                found_c;
  int unsigned         idx_c;

  // Round-robin pick: first eligible requester at or after ptr, wrapping.
  // A requester whose done pulse is high this cycle is masked off.
  always_comb begin
    eligible_c = req_valid & ~req_done_q;
    win_c      = '0;
    found_c    = 1'b0;
    idx_c      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = (32'(ptr_q) + k) % NREQ;
      if (!found_c && eligible_c[PW'(idx_c)]) begin
        found_c = 1'b1;
        win_c   = PW'(idx_c);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_done_d  = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          gnt_d     = win_c;
          paddr_d   = req_addr[32'(win_c)*AWIDTH +: AWIDTH];
          pwdata_d  = req_wdata[32'(win_c)*DWIDTH +: DWIDTH];
          pwrite_d  = req_write[win_c];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Exit on PREADY, or abort once the wait budget is exhausted.
        if (PREADY || ((TIMEOUT != 0) && (cnt_q == CW'(TMAX)))) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          req_done_d  = NREQ'(1) << gnt_q;
          rsp_err_d   = PREADY ? PSLVERR : 1'b1;
          rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
          ptr_d       = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_done_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_done_q  <= req_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign req_done  = req_done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule
